jtopl_eg_ctrl: RTL and testbench

Per-slot envelope phase sequencer for the OPL envelope generator. It walks the 18 operator slots in round-robin order and owns the global 15-bit envelope counter. It keeps a 4-phase state per slot (ATTACK/DECAY/SUSTAIN/RELEASE) and drives the rate-step datapath with `attack`, `base_rate` and `eg_cnt` for the slot being serviced. It sits between the register file (per-slot rates, key-on) and the rate-step/level-update pipeline.

---
 rtl/jtopl_eg_ctrl_if.sv | 42 ++++
 rtl/jtopl_eg_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_jtopl_eg_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_eg_ctrl_if.sv
// ---------------------------------------------------------------------------
// jtopl_eg_ctrl_if
// Bundles the per-slot register-file inputs and the sequencer outputs of the
// OPL envelope phase sequencer.
//   master : register file / pipeline side (drives rates, key-on, level)
//   slave  : jtopl_eg_ctrl (drives slot addressing, counter, registered rate)
// Signals:
//   cen, keyon, arate, drate, rrate, sl, eg_type, eg_level  -> sequencer
//   slot, zero, eg_cnt, out_slot, attack, base_rate, phase,
//   keyon_now, keyoff_now                                    <- sequencer
// ---------------------------------------------------------------------------
interface jtopl_eg_ctrl_if;
  logic        cen;
  logic        keyon;
  logic [3:0]  arate;
  logic [3:0]  drate;
  logic [3:0]  rrate;
  logic [3:0]  sl;
  logic        eg_type;
  logic [9:0]  eg_level;
  logic [4:0]  slot;
  logic        zero;
  logic [14:0] eg_cnt;
  logic [4:0]  out_slot;
  logic        attack;
  logic [4:0]  base_rate;
  logic [1:0]  phase;
  logic        keyon_now;
  logic        keyoff_now;

  modport master (
    output cen, keyon, arate, drate, rrate, sl, eg_type, eg_level,
    input  slot, zero, eg_cnt, out_slot, attack, base_rate, phase,
           keyon_now, keyoff_now
  );

  modport slave (
    input  cen, keyon, arate, drate, rrate, sl, eg_type, eg_level,
    output slot, zero, eg_cnt, out_slot, attack, base_rate, phase,
           keyon_now, keyoff_now
  );
endinterface

// File: rtl/jtopl_eg_ctrl.sv
// ---------------------------------------------------------------------------
// jtopl_eg_ctrl
// Per-slot envelope phase sequencer for the OPL envelope generator. Walks the
// operator slots round-robin, owns the global 15-bit envelope counter, keeps
// an ATTACK/DECAY/SUSTAIN/RELEASE phase per slot and presents the rate-step
// datapath with the rate of the serviced slot one cen later.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : jtopl_eg_ctrl_if.slave (register-file inputs, sequencer outputs)
// Parameters:
//   SLOTS : operator slots per sweep (2..32)
// Configuration macro:
//   JTOPL_EG_HALFRATE_EN : when defined, eg_cnt advances on every second
//                          slot wrap instead of every wrap.
// ---------------------------------------------------------------------------
module jtopl_eg_ctrl #(
  parameter int SLOTS = 18
) (
  input  logic            clk,
  input  logic            rst,
  jtopl_eg_ctrl_if.slave  bus
);

  localparam int         SW        = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

  typedef enum logic [1:0] {
    PH_ATTACK  = 2'd0,
    PH_DECAY   = 2'd1,
    PH_SUSTAIN = 2'd2,
    PH_RELEASE = 2'd3
  } phase_e;

  // Rate presented to the step datapath for the phase a slot is entering.
  function automatic logic [4:0] rate_for_phase(
    input phase_e     ph,
    input logic [3:0] ar,
    input logic [3:0] dr,
    input logic [3:0] rr,
    input logic       et
  );
    logic [4:0] r;
    case (ph)
      PH_ATTACK:  r = {ar, 1'b0};
      PH_DECAY:   r = {dr, 1'b0};
      PH_SUSTAIN: r = et ? 5'd0 : {rr, 1'b0};
      PH_RELEASE: r = {rr, 1'b0};
      default:    r = {rr, 1'b0};
    endcase
    return r;
  endfunction

  logic [4:0]       slot_q, slot_d;
  logic [14:0]      eg_cnt_q, eg_cnt_d;
  phase_e           phase_mem_q [SLOTS];
  phase_e           phase_mem_d [SLOTS];
  logic [SLOTS-1:0] prev_keyon_q, prev_keyon_d;
  logic [4:0]       out_slot_q, out_slot_d;
  logic             attack_q, attack_d;
  logic [4:0]       base_rate_q, base_rate_d;
  phase_e           phase_q, phase_d;
  logic             keyon_now_q, keyon_now_d;
  logic             keyoff_now_q, keyoff_now_d;

  logic [SW-1:0]    slot_idx_s;
  phase_e           cur_phase_s;
  phase_e           next_phase_s;
  logic             prev_kon_s;
  logic             kon_edge_s;
  logic             koff_edge_s;
  logic [4:0]       slx_s;
  logic             wrap_s;
  logic             cnt_inc_s;

  assign slot_idx_s  = slot_q[SW-1:0];
  assign cur_phase_s = phase_mem_q[slot_idx_s];
  assign prev_kon_s  = prev_keyon_q[slot_idx_s];
  assign wrap_s      = (slot_q == LAST_SLOT);

`ifdef JTOPL_EG_HALFRATE_EN
  logic half_tgl_q, half_tgl_d;

  // Divide-by-two toggle: flips on every wrap, counter only advances when set.
  always_comb begin
    half_tgl_d = half_tgl_q;
    if (bus.cen && wrap_s) begin
      half_tgl_d = ~half_tgl_q;
    end else begin
      half_tgl_d = half_tgl_q;
    end
  end

  // Half-rate toggle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_tgl_q <= 1'b0;
    end else begin
      half_tgl_q <= half_tgl_d;
    end
  end

  assign cnt_inc_s = wrap_s & half_tgl_q;
`else
  assign cnt_inc_s = wrap_s;
`endif

  // Next-phase decision for the serviced slot; key edges beat level events.
  always_comb begin
    kon_edge_s   = bus.keyon & ~prev_kon_s;
    koff_edge_s  = ~bus.keyon & prev_kon_s;
    // sl=15 maps to the bottom of the range so DECAY runs all the way down.
    slx_s        = (bus.sl == 4'd15) ? 5'd31 : {1'b0, bus.sl};
    next_phase_s = cur_phase_s;
    if (kon_edge_s) begin
      next_phase_s = PH_ATTACK;
    end else if (koff_edge_s) begin
      next_phase_s = PH_RELEASE;
    end else begin
      case (cur_phase_s)
        PH_ATTACK: begin
          if (bus.eg_level == 10'd0) begin
            next_phase_s = PH_DECAY;
          end else begin
            next_phase_s = PH_ATTACK;
          end
        end
        PH_DECAY: begin
          if (bus.eg_level[9:5] >= slx_s) begin
            next_phase_s = PH_SUSTAIN;
          end else begin
            next_phase_s = PH_DECAY;
          end
        end
        PH_SUSTAIN: next_phase_s = PH_SUSTAIN;
        PH_RELEASE: next_phase_s = PH_RELEASE;
        default:    next_phase_s = PH_RELEASE;
      endcase
    end
  end

  // Next-state for counters, per-slot memory and registered outputs.
  always_comb begin
    slot_d       = slot_q;
    eg_cnt_d     = eg_cnt_q;
    phase_mem_d  = phase_mem_q;
    prev_keyon_d = prev_keyon_q;
    out_slot_d   = out_slot_q;
    attack_d     = attack_q;
    base_rate_d  = base_rate_q;
    phase_d      = phase_q;
    keyon_now_d  = keyon_now_q;
    keyoff_now_d = keyoff_now_q;
    if (bus.cen) begin
      slot_d                   = wrap_s ? 5'd0 : (slot_q + 5'd1);
      eg_cnt_d                 = cnt_inc_s ? (eg_cnt_q + 15'd1) : eg_cnt_q;
      phase_mem_d[slot_idx_s]  = next_phase_s;
      prev_keyon_d[slot_idx_s] = bus.keyon;
      out_slot_d               = slot_q;
      attack_d                 = (next_phase_s == PH_ATTACK);
      base_rate_d              = rate_for_phase(next_phase_s, bus.arate,
                                                bus.drate, bus.rrate,
                                                bus.eg_type);
      phase_d                  = next_phase_s;
      keyon_now_d              = kon_edge_s;
      keyoff_now_d             = koff_edge_s;
    end else begin
      // cen low: everything, pulses included, holds.
      slot_d = slot_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= 5'd0;
      eg_cnt_q     <= 15'd0;
      prev_keyon_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        phase_mem_q[i] <= PH_RELEASE;
      end
      out_slot_q   <= 5'd0;
      attack_q     <= 1'b0;
      base_rate_q  <= 5'd0;
      phase_q      <= PH_RELEASE;
      keyon_now_q  <= 1'b0;
      keyoff_now_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      eg_cnt_q     <= eg_cnt_d;
      prev_keyon_q <= prev_keyon_d;
      phase_mem_q  <= phase_mem_d;
      out_slot_q   <= out_slot_d;
      attack_q     <= attack_d;
      base_rate_q  <= base_rate_d;
      phase_q      <= phase_d;
      keyon_now_q  <= keyon_now_d;
      keyoff_now_q <= keyoff_now_d;
    end
  end

  assign bus.slot       = slot_q;
  assign bus.zero       = (slot_q == 5'd0);
  assign bus.eg_cnt     = eg_cnt_q;
  assign bus.out_slot   = out_slot_q;
  assign bus.attack     = attack_q;
  assign bus.base_rate  = base_rate_q;
  assign bus.phase      = phase_q;
  assign bus.keyon_now  = keyon_now_q;
  assign bus.keyoff_now = keyoff_now_q;

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtopl_eg_ctrl
// Self-checking bench for jtopl_eg_ctrl: directed envelope walk on slot 5,
// randomized key/level/rate traffic with cen gaps, and a mid-sweep reset.
// Expected values come from a sweep-level reference model.
// ---------------------------------------------------------------------------
module tb_jtopl_eg_ctrl;
  localparam int SLOTS = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtopl_eg_ctrl_if bus();

  jtopl_eg_ctrl #(.SLOTS(SLOTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_slot;
  int m_cycles;
  int m_phase [SLOTS];
  bit m_prev  [SLOTS];
  bit kst     [SLOTS];
  int e_out_slot, e_attack, e_base, e_phase, e_kon, e_koff;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_eg_cnt();
`ifdef JTOPL_EG_HALFRATE_EN
    return ((m_cycles / SLOTS) / 2) % 32768;
`else
    return (m_cycles / SLOTS) % 32768;
`endif
  endfunction

  task automatic model_reset();
    m_slot = 0;
    m_cycles = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_phase[i] = 3;
      m_prev[i]  = 1'b0;
      kst[i]     = 1'b0;
    end
    e_out_slot = 0; e_attack = 0; e_base = 0;
    e_phase = 3; e_kon = 0; e_koff = 0;
  endtask

  task automatic model_step(input bit k, input int ar, input int dr,
                            input int rr, input int s_l, input bit et,
                            input int lvl);
    int s, ph, nph, slx;
    s = m_slot;
    ph = m_phase[s];
    slx = (s_l == 15) ? 31 : s_l;
    e_kon = 0;
    e_koff = 0;
    if (k && !m_prev[s]) begin
      nph = 0; e_kon = 1;
    end else if (!k && m_prev[s]) begin
      nph = 3; e_koff = 1;
    end else if (ph == 0 && lvl == 0) begin
      nph = 1;
    end else if (ph == 1 && (lvl / 32) >= slx) begin
      nph = 2;
    end else begin
      nph = ph;
    end
    case (nph)
      0:       e_base = ar * 2;
      1:       e_base = dr * 2;
      2:       e_base = et ? 0 : rr * 2;
      default: e_base = rr * 2;
    endcase
    e_attack   = (nph == 0) ? 1 : 0;
    e_phase    = nph;
    e_out_slot = s;
    m_phase[s] = nph;
    m_prev[s]  = k;
    m_slot     = (s + 1) % SLOTS;
    m_cycles++;
  endtask

  task automatic check_all();
    chk_val("slot",       int'(bus.slot),       m_slot);
    chk_val("zero",       int'(bus.zero),       (m_slot == 0) ? 1 : 0);
    chk_val("eg_cnt",     int'(bus.eg_cnt),     exp_eg_cnt());
    chk_val("out_slot",   int'(bus.out_slot),   e_out_slot);
    chk_val("attack",     int'(bus.attack),     e_attack);
    chk_val("base_rate",  int'(bus.base_rate),  e_base);
    chk_val("phase",      int'(bus.phase),      e_phase);
    chk_val("keyon_now",  int'(bus.keyon_now),  e_kon);
    chk_val("keyoff_now", int'(bus.keyoff_now), e_koff);
  endtask

  task automatic drive(input bit c, input bit k, input int ar, input int dr,
                       input int rr, input int s_l, input bit et,
                       input int lvl);
    bus.cen      = c;
    bus.keyon    = k;
    bus.arate    = 4'(ar);
    bus.drate    = 4'(dr);
    bus.rrate    = 4'(rr);
    bus.sl       = 4'(s_l);
    bus.eg_type  = et;
    bus.eg_level = 10'(lvl);
    if (c) model_step(k, ar, dr, rr, s_l, et, lvl);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(1'b1, kst[m_slot], int'($urandom % 16), int'($urandom % 16),
          int'($urandom % 16), int'($urandom % 16), 1'($urandom % 2), 1023);
  endtask

  task automatic goto_slot(input int t);
    while (m_slot != t) idle();
  endtask

  task automatic chk_reset_values(input string tag);
    chk_val({tag, ".slot"},       int'(bus.slot),       0);
    chk_val({tag, ".zero"},       int'(bus.zero),       1);
    chk_val({tag, ".eg_cnt"},     int'(bus.eg_cnt),     0);
    chk_val({tag, ".out_slot"},   int'(bus.out_slot),   0);
    chk_val({tag, ".attack"},     int'(bus.attack),     0);
    chk_val({tag, ".base_rate"},  int'(bus.base_rate),  0);
    chk_val({tag, ".phase"},      int'(bus.phase),      3);
    chk_val({tag, ".keyon_now"},  int'(bus.keyon_now),  0);
    chk_val({tag, ".keyoff_now"}, int'(bus.keyoff_now), 0);
  endtask

  initial begin
    bus.cen = 1'b0; bus.keyon = 1'b0; bus.arate = 4'd0; bus.drate = 4'd0;
    bus.rrate = 4'd0; bus.sl = 4'd0; bus.eg_type = 1'b0;
    bus.eg_level = 10'd0;
    rst = 1'b1;
    model_reset();
    #22;
    chk_reset_values("rst");
    @(negedge clk);
    rst = 1'b0;

    // 40 plain cycles: slot sequence, zero and eg_cnt
    for (int i = 0; i < 40; i++) idle();
    chk_val("run40.slot", int'(bus.slot), 4);
`ifdef JTOPL_EG_HALFRATE_EN
    chk_val("run40.eg_cnt", int'(bus.eg_cnt), 1);
`else
    chk_val("run40.eg_cnt", int'(bus.eg_cnt), 2);
`endif

    // slot 5 key-on edge
    goto_slot(5);
    kst[5] = 1'b1;
    drive(1'b1, 1'b1, 10, 3, 7, 4, 1'b0, 10'h200);
    chk_val("kon5.out_slot", int'(bus.out_slot), 5);
    chk_val("kon5.keyon_now", int'(bus.keyon_now), 1);
    chk_val("kon5.attack", int'(bus.attack), 1);
    chk_val("kon5.base_rate", int'(bus.base_rate), 20);
    chk_val("kon5.phase", int'(bus.phase), 0);
    // next sweep: level reaches 0 -> DECAY
    goto_slot(5);
    drive(1'b1, 1'b1, 10, 6, 7, 4, 1'b0, 0);
    chk_val("dec5.phase", int'(bus.phase), 1);
    chk_val("dec5.base_rate", int'(bus.base_rate), 12);
    chk_val("dec5.keyon_now", int'(bus.keyon_now), 0);
    // following sweep: level[9:5]=4 >= sl=4 -> SUSTAIN, eg_type=1
    goto_slot(5);
    drive(1'b1, 1'b1, 10, 6, 7, 4, 1'b1, 10'h080);
    chk_val("sus5.phase", int'(bus.phase), 2);
    chk_val("sus5.base_rate_hold", int'(bus.base_rate), 0);
    goto_slot(5);
    drive(1'b1, 1'b1, 10, 6, 7, 4, 1'b0, 10'h080);
    chk_val("sus5.base_rate_perc", int'(bus.base_rate), 14);
    // key-off
    goto_slot(5);
    kst[5] = 1'b0;
    drive(1'b1, 1'b0, 10, 6, 9, 4, 1'b0, 10'h080);
    chk_val("koff5.keyoff_now", int'(bus.keyoff_now), 1);
    chk_val("koff5.phase", int'(bus.phase), 3);
    chk_val("koff5.base_rate", int'(bus.base_rate), 18);

    // cen low: nothing moves, pulse holds
    for (int i = 0; i < 3; i++)
      drive(1'b0, ~kst[m_slot], 15, 15, 15, 0, 1'b0, 0);
    chk_val("cen0.keyoff_hold", int'(bus.keyoff_now), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit c;
      int s, lvl;
      c = (($urandom % 8) != 0);
      s = m_slot;
      if (c && ($urandom % 6) == 0) kst[s] = ~kst[s];
      lvl = (($urandom % 4) == 0) ? 0 : int'($urandom % 1024);
      drive(c, kst[s], int'($urandom % 16), int'($urandom % 16),
            int'($urandom % 16), int'($urandom % 16), 1'($urandom % 2), lvl);
    end

    // put slot 3 into DECAY, then reset at slot 9
    goto_slot(3);
    if (kst[3]) begin
      kst[3] = 1'b0;
      idle();
      goto_slot(3);
    end
    kst[3] = 1'b1;
    drive(1'b1, 1'b1, 5, 5, 5, 15, 1'b0, 10'h200);
    goto_slot(3);
    drive(1'b1, 1'b1, 5, 5, 5, 15, 1'b0, 0);
    chk_val("pre_rst.phase3", int'(bus.phase), 1);
    goto_slot(9);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    @(posedge clk);
    #1;
    chk_reset_values("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    goto_slot(3);
    drive(1'b1, 1'b0, 5, 5, 5, 15, 1'b0, 0);
    chk_val("post_rst.out_slot", int'(bus.out_slot), 3);
    chk_val("post_rst.phase3", int'(bus.phase), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
